// File: rtl/dm_pkg.sv
// Shared types and constants for the four-bank data-memory controller.
package dm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } dm_state_e;

  localparam int unsigned NUM_BANKS  = 4;
  localparam int unsigned BANK_SEL_W = 2;
  localparam int unsigned IDX_W      = 10;

  localparam logic [BANK_SEL_W-1:0] BANK0 = 2'd0;
  localparam logic [BANK_SEL_W-1:0] BANK1 = 2'd1;
  localparam logic [BANK_SEL_W-1:0] BANK2 = 2'd2;
  localparam logic [BANK_SEL_W-1:0] BANK3 = 2'd3;

endpackage

// File: rtl/dm_bank_ctrl_if.sv
// Host loader and processor datapath signals seen by the data-memory controller.
interface dm_bank_ctrl_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned BUS_W  = 18
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              host_start;
  logic              busy;
  logic              done;
  logic              start_process;
  logic              end_process;
  logic [ADDR_W-1:0] ar_out;
  logic [BUS_W-1:0]  bus_out;
  logic              dm_en;
  logic              dm_en_ram1;
  logic              dm_en_ram2;
  logic              dm_en_ram3;
  logic              dm_en_ram4;
  logic [DATA_W-1:0] dm_out;

  modport master (
    output host_req, host_we, host_addr, host_wdata, host_start, end_process,
    output ar_out, bus_out, dm_en, dm_en_ram1, dm_en_ram2, dm_en_ram3, dm_en_ram4,
    input  host_ready, host_rdata, host_rvalid, busy, done, start_process, dm_out
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, host_start, end_process,
    input  ar_out, bus_out, dm_en, dm_en_ram1, dm_en_ram2, dm_en_ram3, dm_en_ram4,
    output host_ready, host_rdata, host_rvalid, busy, done, start_process, dm_out
  );
endinterface

// File: rtl/dm_bank_ram.sv
// Single-port synchronous RAM bank; registered read returns pre-write data.
module dm_bank_ram #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dm_bank_ctrl.sv
// Data-memory controller: host owns the banks when idle, processor owns them during a run.
module dm_bank_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned BUS_W      = 18,
  parameter int unsigned BANK_DEPTH = 2 ** (ADDR_W - 2)
) (
  input logic          clk,
  input logic          rst_n,
  dm_bank_ctrl_if.slave bus
);

  localparam int unsigned IW = ADDR_W - BANK_SEL_W;

  dm_state_e state_q, state_d;
  logic      run;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (bus.host_start) state_d = StRun;
      StRun:          if (bus.end_process) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign run               = (state_q == StRun);
  assign bus.busy          = run;
  assign bus.start_process = run;
  assign bus.done          = (state_q == StDone);
  assign bus.host_ready    = bus.host_req & ~run;

  logic                  host_wr, host_rd;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     wdata;
  logic [NUM_BANKS-1:0]  proc_en;
  logic [NUM_BANKS-1:0]  we;
  logic [DATA_W-1:0]     rdata_bank [NUM_BANKS];
  logic [BANK_SEL_W-1:0] rd_bank_q;
  logic                  rvalid_q;
  logic [DATA_W-1:0]     rd_word;
  logic                  bus_hi_unused;

  assign host_wr  = bus.host_ready & bus.host_we;
  assign host_rd  = bus.host_ready & ~bus.host_we;
  assign sel_addr = run ? bus.ar_out : bus.host_addr;
  assign wdata    = run ? bus.bus_out[DATA_W-1:0] : bus.host_wdata;
  assign proc_en  = {bus.dm_en_ram4, bus.dm_en_ram3, bus.dm_en_ram2, bus.dm_en_ram1};
  assign bus_hi_unused = ^bus.bus_out[BUS_W-1:DATA_W];

  // Overlapping processor enables on one bank collapse into a single write.
  always_comb begin
    we = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (run) begin
        we[b] = (bus.dm_en && bus.ar_out[ADDR_W-1 -: BANK_SEL_W] == BANK_SEL_W'(b)) ||
                proc_en[b];
      end else begin
        we[b] = host_wr && bus.host_addr[ADDR_W-1 -: BANK_SEL_W] == BANK_SEL_W'(b);
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    dm_bank_ram #(
      .DEPTH  (BANK_DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IW)
    ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we[g]),
      .addr  (sel_addr[IW-1:0]),
      .wdata (wdata),
      .rdata (rdata_bank[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank_q <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      rd_bank_q <= sel_addr[ADDR_W-1 -: BANK_SEL_W];
      rvalid_q  <= host_rd;
    end
  end

  assign rd_word         = rdata_bank[rd_bank_q];
  assign bus.dm_out      = rd_word;
  assign bus.host_rvalid = rvalid_q;
  assign bus.host_rdata  = rvalid_q ? rd_word : '0;

endmodule

// File: tb/tb_dm_bank_ctrl.sv
// Directed bench for dm_bank_ctrl with a per-cycle behavioural memory/mode model.
module tb_dm_bank_ctrl;

  logic clk;
  logic rst_n;

  dm_bank_ctrl_if #(.ADDR_W(12), .DATA_W(12), .BUS_W(18)) dut_if ();

  dm_bank_ctrl #(
    .ADDR_W (12),
    .DATA_W (12),
    .BUS_W  (18)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: 0 = idle, 1 = run, 2 = done.
  int          m_mode = 0;
  logic [11:0] m_mem   [4][1024];
  bit          m_known [4][1024];
  bit          exp_rvalid = 0;
  bit          rd_known   = 0;
  logic [11:0] exp_rdata  = '0;
  bit          dm_chk     = 0;
  logic [11:0] exp_dm     = '0;
  int          hb, hi, ab, ai;
  bit          acc;
  logic [3:0]  en_vec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode     = 0;
      exp_rvalid = 0;
      dm_chk     = 0;
    end else begin
      hb  = int'(dut_if.host_addr[11:10]);
      hi  = int'(dut_if.host_addr[9:0]);
      ab  = int'(dut_if.ar_out[11:10]);
      ai  = int'(dut_if.ar_out[9:0]);
      acc = dut_if.host_req && m_mode != 1;
      exp_rvalid = acc && !dut_if.host_we;
      if (exp_rvalid) begin
        exp_rdata = m_mem[hb][hi];
        rd_known  = m_known[hb][hi];
      end
      if (m_mode == 1) begin
        dm_chk = m_known[ab][ai];
        exp_dm = m_mem[ab][ai];
        en_vec = {dut_if.dm_en_ram4, dut_if.dm_en_ram3, dut_if.dm_en_ram2, dut_if.dm_en_ram1};
        if (dut_if.dm_en) en_vec[ab] = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (en_vec[b]) begin
            m_mem[b][ai]   = dut_if.bus_out[11:0];
            m_known[b][ai] = 1'b1;
          end
        end
        if (dut_if.end_process) m_mode = 2;
      end else begin
        dm_chk = 0;
        if (acc && dut_if.host_we) begin
          m_mem[hb][hi]   = dut_if.host_wdata;
          m_known[hb][hi] = 1'b1;
        end
        if (dut_if.host_start) m_mode = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", dut_if.busy, m_mode == 1);
    check("start_process", dut_if.start_process, m_mode == 1);
    check("done", dut_if.done, m_mode == 2);
    check("host_ready", dut_if.host_ready, dut_if.host_req && m_mode != 1);
    check("host_rvalid", dut_if.host_rvalid, exp_rvalid);
    if (exp_rvalid && rd_known) check("host_rdata", dut_if.host_rdata, exp_rdata);
    if (dm_chk) check("dm_out", dut_if.dm_out, exp_dm);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [11:0] a, input logic [11:0] d);
    dut_if.host_req = 1'b1; dut_if.host_we = 1'b1;
    dut_if.host_addr = a; dut_if.host_wdata = d;
    tick();
    dut_if.host_req = 1'b0; dut_if.host_we = 1'b0;
  endtask

  task automatic host_read(input string name, input logic [11:0] a, input logic [11:0] d);
    dut_if.host_req = 1'b1; dut_if.host_we = 1'b0; dut_if.host_addr = a;
    tick();
    dut_if.host_req = 1'b0;
    check({name, "_rvalid"}, dut_if.host_rvalid, 1);
    check({name, "_rdata"}, dut_if.host_rdata, d);
  endtask

  task automatic proc_idle();
    dut_if.dm_en = 0; dut_if.dm_en_ram1 = 0; dut_if.dm_en_ram2 = 0;
    dut_if.dm_en_ram3 = 0; dut_if.dm_en_ram4 = 0;
  endtask

  logic [11:0] t1_addr [3];
  logic [11:0] t1_data [3];

  initial begin
    rst_n = 1'b0;
    dut_if.host_req = 0; dut_if.host_we = 0; dut_if.host_addr = '0; dut_if.host_wdata = '0;
    dut_if.host_start = 0; dut_if.end_process = 0; dut_if.ar_out = '0; dut_if.bus_out = '0;
    proc_idle();
    #2;
    check("rst_host_ready", dut_if.host_ready, 0);
    check("rst_host_rvalid", dut_if.host_rvalid, 0);
    check("rst_host_rdata", dut_if.host_rdata, 0);
    check("rst_busy", dut_if.busy, 0);
    check("rst_done", dut_if.done, 0);
    check("rst_start_process", dut_if.start_process, 0);
    check("rst_dm_out", dut_if.dm_out, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Host load, then back-to-back readback.
    t1_addr[0] = 12'h000; t1_data[0] = 12'h0A5;
    t1_addr[1] = 12'h401; t1_data[1] = 12'h3C1;
    t1_addr[2] = 12'hC3F; t1_data[2] = 12'h7FF;
    for (int i = 0; i < 3; i++) host_write(t1_addr[i], t1_data[i]);
    dut_if.host_req = 1'b1; dut_if.host_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dut_if.host_addr = t1_addr[i];
      tick();
      check("t1_rvalid", dut_if.host_rvalid, 1);
      check("t1_rdata", dut_if.host_rdata, t1_data[i]);
    end
    dut_if.host_req = 1'b0;
    tick();
    check("t1_rvalid_drop", dut_if.host_rvalid, 0);

    // Start a run; host requests are refused.
    dut_if.host_start = 1'b1;
    tick();
    dut_if.host_start = 1'b0;
    check("t2_start_process", dut_if.start_process, 1);
    check("t2_busy", dut_if.busy, 1);
    check("t2_done", dut_if.done, 0);
    dut_if.host_req = 1'b1; dut_if.host_addr = 12'h000;
    #1;
    check("t2_ready_in_run", dut_if.host_ready, 0);
    tick();
    check("t2_no_rvalid", dut_if.host_rvalid, 0);
    dut_if.host_req = 1'b0;

    // Processor write via dm_en, then read back.
    dut_if.ar_out = 12'h805; dut_if.bus_out = 18'h3F123; dut_if.dm_en = 1'b1;
    tick();
    dut_if.dm_en = 1'b0;
    tick();
    check("t3_dm_out", dut_if.dm_out, 12'h123);

    // Broadcast to all four banks.
    dut_if.ar_out = 12'h010; dut_if.bus_out = 18'h00456;
    dut_if.dm_en_ram1 = 1; dut_if.dm_en_ram2 = 1; dut_if.dm_en_ram3 = 1; dut_if.dm_en_ram4 = 1;
    tick();
    proc_idle();

    // Read-during-write returns the old word.
    dut_if.ar_out = 12'h020; dut_if.bus_out = 18'h00111; dut_if.dm_en = 1'b1;
    tick();
    dut_if.bus_out = 18'h00222;
    tick();
    dut_if.dm_en = 1'b0;
    check("t5_old_data", dut_if.dm_out, 12'h111);
    tick();
    check("t5_new_data", dut_if.dm_out, 12'h222);

    dut_if.end_process = 1'b1;
    tick();
    dut_if.end_process = 1'b0;
    check("t2_end_start_process", dut_if.start_process, 0);
    check("t2_end_done", dut_if.done, 1);
    check("t2_end_busy", dut_if.busy, 0);

    host_read("t4_b0", 12'h010, 12'h456);
    host_read("t4_b1", 12'h410, 12'h456);
    host_read("t4_b2", 12'h810, 12'h456);
    host_read("t4_b3", 12'hC10, 12'h456);
    host_read("t3_dump", 12'h805, 12'h123);
    check("t4_done_sticky", dut_if.done, 1);

    // Second run, write, then reset mid-run.
    dut_if.host_start = 1'b1;
    tick();
    dut_if.host_start = 1'b0;
    dut_if.ar_out = 12'h123; dut_if.bus_out = 18'h20BEE; dut_if.dm_en = 1'b1;
    tick();
    dut_if.dm_en = 1'b0;
    dut_if.ar_out = 12'h000;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_start_process_async", dut_if.start_process, 0);
    check("t6_busy", dut_if.busy, 0);
    check("t6_done", dut_if.done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    host_read("t6_kept", 12'h123, 12'hBEE);
    host_read("t6_kept_old", 12'h410, 12'h456);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dm_bank_ctrl.md
Name: dm_bank_ctrl

Overview:
Data-memory controller between the host loader and the processor datapath. It owns four 12-bit data RAM banks and arbitrates access to them:
- the host loads operands and dumps results while the processor is idle;
- the processor has exclusive access during a run.
It generates start_process and consumes end_process, so it sequences the whole compute job.

Parameters:
ADDR_W, 12, address width; the top 2 bits select the bank.
DATA_W, 12, stored word width.
BUS_W, 18, processor bus width; the low DATA_W bits are written.
BANK_DEPTH, 1024, words per bank (2**(ADDR_W-2)).

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
host_req  in  1  host access request (valid)
host_we  in  1  1=write, 0=read; qualified by host_req
host_addr  in  ADDR_W  host word address
host_wdata  in  DATA_W  host write data
host_ready  out  1  host request accepted this cycle
host_rdata  out  DATA_W  host read data
host_rvalid  out  1  host_rdata valid, one-cycle pulse
host_start  in  1  pulse: begin processor run
busy  out  1  run in progress
done  out  1  run finished; sticky until next host_start
start_process  out  1  run enable to processor, level
end_process  in  1  processor completion flag
ar_out  in  ADDR_W  processor address register
bus_out  in  BUS_W  processor bus, write data source
dm_en  in  1  processor write to bank ar_out[11:10]
dm_en_ram1..dm_en_ram4  in  1 each  processor write to bank 0..3 at ar_out[9:0]
dm_out  out  DATA_W  processor read data

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: host_ready=0, host_rvalid=0, host_rdata=0, busy=0, done=0, start_process=0, dm_out=0. RAM contents are not cleared.
- IDLE/DONE, host access:
  - host_ready = host_req, combinational, only in IDLE/DONE.
  - Accepted write: the bank selected by host_addr[11:10] is written at host_addr[9:0] on the same edge.
  - Accepted read: host_rdata and host_rvalid=1 appear exactly 1 cycle later.
  - Back-to-back reads are allowed, one per cycle.
- Leaving IDLE/DONE: host_start moves the FSM to RUN on the next edge, with start_process=1, busy=1, done=0.
- host_start and host_req in the same cycle: the host access completes in that cycle, then the FSM enters RUN.
- RUN, processor access:
  - host_ready=0 and host requests are ignored (no rvalid). host_start is ignored.
  - dm_out is a registered read of bank ar_out[11:10] at ar_out[9:0]: 1-cycle latency, updated every cycle.
  - Writes use data bus_out[DATA_W-1:0] at index ar_out[9:0].
  - dm_en writes the bank selected by ar_out[11:10]. dm_en_ramN writes bank N-1 regardless of ar_out[11:10].
  - Several enables in one cycle write every selected bank (broadcast). Duplicate selection of the same bank counts as a single write.
  - Read-during-write to the same address: dm_out returns the OLD data.
- Leaving RUN: end_process=1 moves the FSM to DONE on the next edge, with start_process=0, busy=0, done=1. end_process is ignored outside RUN.
- Processor write enables outside RUN are ignored.
- DONE behaves as IDLE for host access; done stays 1 until host_start.
- Asynchronous reset mid-RUN: start_process drops immediately and the FSM returns to IDLE. Memory keeps partially written data.
- Address wrap: indices use only [9:0]; there is no out-of-range case.

Decomposition:
- Shared package dm_pkg: FSM state enum (IDLE, RUN, DONE), BANK_SEL_W=2, index-width constant, bank-number constants.
- One sub-module, dm_bank_ram:
  - single-port synchronous RAM, DEPTH x DATA_W;
  - we, addr, wdata, registered rdata, read-old-data semantics;
  - instantiated four times.
- Top-level content: FSM, port muxing, and write-enable decode.

Test Plan:
1. Host writes 0x0A5 at addr 0x000, 0x3C1 at 0x401, 0x7FF at 0xC3F, then reads each back -> host_rvalid 1 cycle after each accept, host_rdata returns 0x0A5, 0x3C1, 0x7FF.
2. host_start pulse -> next cycle start_process=1, busy=1, done=0. A host_req in RUN gives host_ready=0 and no rvalid. end_process=1 -> next cycle start_process=0, done=1, busy=0.
3. In RUN, ar_out=0x805, bus_out=0x3F123, dm_en=1 -> bank2[5]=0x123. Then ar_out=0x805 with no write -> dm_out=0x123 one cycle later.
4. In RUN, ar_out=0x010, dm_en_ram1..4 all 1, bus_out=0x00456 -> host dump after done reads 0x456 at 0x010, 0x410, 0x810, 0xC10.
5. Same-cycle read and write to 0x020 in RUN (old=0x111, new=0x222) -> dm_out=0x111 next cycle, 0x222 the cycle after.
6. Assert rst_n=0 mid-RUN -> start_process=0 asynchronously, busy=0, done=0. After release, host read of data written before reset returns the stored value.
